// File: rtl/ct_cmp_pkg.sv
// Shared types and constants for the constant-time buffer comparator.
package ct_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE,
    CMP_ISSUE,
    CMP_DRAIN,
    CMP_DONE
  } cmp_state_e;

  localparam int CMP_DATA_W = 32;

endpackage

// File: rtl/set_equal.sv
// Word equality comparator: rd_o[0] is 1 when both operands match; upper bits are zero.
module set_equal #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] rd_o
);

  assign rd_o = {{(W-1){1'b0}}, (a_i == b_i)};

endmodule

// File: rtl/ct_compare_ctrl.sv
// Constant-time comparator controller: walks len words of two buffers, folds any
// mismatch into a sticky accumulator, and reports the result after the full walk.
module ct_compare_ctrl
  import ct_cmp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_W-1:0]     a_base_i,
  input  logic [ADDR_W-1:0]     b_base_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  busy_o,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_a_addr_o,
  output logic [ADDR_W-1:0]     rd_b_addr_o,
  input  logic [CMP_DATA_W-1:0] rd_a_data_i,
  input  logic [CMP_DATA_W-1:0] rd_b_data_i,
  output logic                  done_o,
  output logic                  equal_o
);

  cmp_state_e r_state;
  cmp_state_e w_state_next;

  logic [ADDR_W-1:0]     r_a_base, r_b_base, r_a_addr, r_b_addr;
  logic [LEN_W-1:0]      r_len, r_idx;
  logic                  r_acc, r_rd_vld, r_rd_en, r_done, r_equal;
  logic [CMP_DATA_W-1:0] w_rd;
  logic                  w_word_ne, w_last_issue, w_abort;
  logic [ADDR_W-1:0]     w_offs;
  logic                  w_unused_rd;

  set_equal #(.W(CMP_DATA_W)) u_set_equal (
    .a_i  (rd_a_data_i),
    .b_i  (rd_b_data_i),
    .rd_o (w_rd)
  );

  assign w_unused_rd  = ^w_rd[CMP_DATA_W-1:1];
  assign w_word_ne    = r_rd_vld & ~w_rd[0];
  assign w_last_issue = (r_idx == (r_len - LEN_W'(1)));
  assign w_abort      = abort_i & (r_state != CMP_IDLE);
  assign w_offs       = ADDR_W'(r_idx) + ADDR_W'(1);

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = CMP_IDLE;
    end else begin
      case (r_state)
        CMP_IDLE:  if (start_i) w_state_next = (len_i == '0) ? CMP_DONE : CMP_ISSUE;
        CMP_ISSUE: if (w_last_issue) w_state_next = CMP_DRAIN;
        CMP_DRAIN: w_state_next = CMP_DONE;
        default:   w_state_next = CMP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= CMP_IDLE;
      r_a_base <= '0;
      r_b_base <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_acc    <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_en  <= 1'b0;
      r_done   <= 1'b0;
      r_equal  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rd_vld <= r_rd_en;
      r_done   <= 1'b0;
      if (w_abort) begin
        r_rd_en  <= 1'b0;
        r_rd_vld <= 1'b0;
        r_equal  <= 1'b0;
      end else begin
        case (r_state)
          CMP_IDLE: begin
            if (start_i) begin
              r_a_base <= a_base_i;
              r_b_base <= b_base_i;
              r_a_addr <= a_base_i;
              r_b_addr <= b_base_i;
              r_len    <= len_i;
              r_idx    <= '0;
              r_acc    <= 1'b0;
              if (len_i == '0) begin
                r_done  <= 1'b1;
                r_equal <= 1'b1;
              end else begin
                r_rd_en <= 1'b1;
                r_equal <= 1'b0;
              end
            end
          end
          CMP_ISSUE: begin
            // Accumulate every returned word; never exit early on mismatch.
            r_acc <= r_acc | w_word_ne;
            if (w_last_issue) begin
              r_rd_en <= 1'b0;
            end else begin
              r_idx    <= r_idx + LEN_W'(1);
              r_a_addr <= r_a_base + w_offs;
              r_b_addr <= r_b_base + w_offs;
            end
          end
          CMP_DRAIN: begin
            r_acc   <= r_acc | w_word_ne;
            r_done  <= 1'b1;
            r_equal <= ~(r_acc | w_word_ne);
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign busy_o      = (r_state != CMP_IDLE);
  assign rd_en_o     = r_rd_en;
  assign rd_a_addr_o = r_a_addr;
  assign rd_b_addr_o = r_b_addr;
  assign done_o      = r_done;
  assign equal_o     = r_equal;

endmodule

// File: tb/tb_ct_compare_ctrl.sv
// Directed bench for ct_compare_ctrl with a two-port registered-read word memory model.
module tb_ct_compare_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, abort_i;
  logic [9:0]  a_base_i, b_base_i;
  logic [7:0]  len_i;
  logic        busy_o, rd_en_o, done_o, equal_o;
  logic [9:0]  rd_a_addr_o, rd_b_addr_o;
  logic [31:0] rd_a_data_i = '0;
  logic [31:0] rd_b_data_i = '0;
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  logic        last_eq = 1'b0;
  logic        seen;

  ct_compare_ctrl #(.ADDR_W(10), .LEN_W(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .a_base_i    (a_base_i),
    .b_base_i    (b_base_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .rd_en_o     (rd_en_o),
    .rd_a_addr_o (rd_a_addr_o),
    .rd_b_addr_o (rd_b_addr_o),
    .rd_a_data_i (rd_a_data_i),
    .rd_b_data_i (rd_b_data_i),
    .done_o      (done_o),
    .equal_o     (equal_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (rd_en_o) begin
      rd_a_data_i <= mem[rd_a_addr_o];
      rd_b_data_i <= mem[rd_b_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation, started in the idle cycle after the call; optional start poke while busy.
  task automatic run_op(input string tag, input logic [9:0] ab, input logic [9:0] bb,
                        input logic [7:0] ln, input logic exp_eq, input int poke_cyc,
                        input logic with_abort);
    int         reads;
    int         done_cyc;
    int         exp_cyc;
    logic [9:0] ea, eb;
    reads    = 0;
    done_cyc = 0;
    exp_cyc  = (ln == 8'd0) ? 1 : int'(ln) + 2;
    @(posedge clk_i); #1;
    check({tag, " idle busy"}, 32'(busy_o), 32'd0);
    check({tag, " idle done"}, 32'(done_o), 32'd0);
    check({tag, " held equal"}, 32'(equal_o), 32'(last_eq));
    a_base_i = ab; b_base_i = bb; len_i = ln; start_i = 1'b1; abort_i = with_abort;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    a_base_i = ~ab; b_base_i = ~bb; len_i = 8'd3;
    for (int c = 1; c <= 300; c++) begin
      if (c == poke_cyc) begin
        start_i = 1'b1; a_base_i = 10'h155; b_base_i = 10'h2AA; len_i = 8'd1;
      end
      if (c == 1 && ln != 8'd0) check({tag, " equal cleared"}, 32'(equal_o), 32'd0);
      if (rd_en_o) begin
        ea = ab + 10'(reads);
        eb = bb + 10'(reads);
        check({tag, " a addr"}, 32'(rd_a_addr_o), 32'(ea));
        check({tag, " b addr"}, 32'(rd_b_addr_o), 32'(eb));
        reads++;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    start_i = 1'b0;
    check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, " read count"}, 32'(reads), 32'(ln));
    check({tag, " equal"}, 32'(equal_o), 32'(exp_eq));
    check({tag, " busy at done"}, 32'(busy_o), 32'd1);
    $display("op %s: base_a=0x%0h base_b=0x%0h len=%0d done_cycle=%0d equal=%0b", tag, ab, bb,
             ln, done_cyc, equal_o);
    last_eq = exp_eq;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      mem[10'h10 + i] = 32'(i + 1);
      mem[10'h20 + i] = 32'(i + 1);
      mem[10'h30 + i] = 32'(i + 1);
      mem[10'h40 + i] = 32'(i + 1);
      mem[10'h60 + i] = 32'(i + 1);
      mem[10'h50 + i] = 32'(i + 5);
    end
    mem[10'h30] = 32'd9;
    mem[10'h43] = 32'd5;
    mem[10'h63] = 32'h8000_0004;
    mem[10'h3FE] = 32'd5;
    mem[10'h3FF] = 32'd6;
    mem[10'h000] = 32'd7;
    mem[10'h001] = 32'd8;

    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    a_base_i = '0; b_base_i = '0; len_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset rd_en", 32'(rd_en_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset equal", 32'(equal_o), 32'd0);
    check("reset a addr", 32'(rd_a_addr_o), 32'd0);
    check("reset b addr", 32'(rd_b_addr_o), 32'd0);
    rst_ni = 1'b1;

    run_op("eq4",        10'h010, 10'h020, 8'd4, 1'b1, 0, 1'b0);
    run_op("ne_word0",   10'h030, 10'h020, 8'd4, 1'b0, 0, 1'b0);
    run_op("ne_last",    10'h040, 10'h020, 8'd4, 1'b0, 0, 1'b0);
    run_op("ne_msb",     10'h060, 10'h020, 8'd4, 1'b0, 0, 1'b0);
    run_op("len0",       10'h030, 10'h020, 8'd0, 1'b1, 0, 1'b0);
    run_op("len1",       10'h013, 10'h023, 8'd1, 1'b1, 0, 1'b0);
    run_op("wrap_eq",    10'h3FE, 10'h050, 8'd4, 1'b1, 0, 1'b0);
    run_op("wrap_ne",    10'h3FE, 10'h010, 8'd4, 1'b0, 0, 1'b0);
    run_op("busy_poke",  10'h010, 10'h020, 8'd4, 1'b1, 2, 1'b0);
    run_op("abort_start",10'h030, 10'h020, 8'd4, 1'b0, 0, 1'b1);

    // Abort in IDLE must leave the held result alone.
    @(posedge clk_i); #1;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("idle abort busy", 32'(busy_o), 32'd0);
    check("idle abort equal", 32'(equal_o), 32'(last_eq));
    $display("op idle_abort: busy=%0b equal=%0b", busy_o, equal_o);

    run_op("pre_abort",  10'h010, 10'h020, 8'd4, 1'b1, 0, 1'b0);
    @(posedge clk_i); #1;
    a_base_i = 10'h010; b_base_i = 10'h020; len_i = 8'd8; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("abort busy before", 32'(busy_o), 32'd1);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort rd_en", 32'(rd_en_o), 32'd0);
    check("abort done", 32'(done_o), 32'd0);
    check("abort equal", 32'(equal_o), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk_i); #1;
      if (done_o || rd_en_o || busy_o) seen = 1'b1;
    end
    check("abort quiet", 32'(seen), 32'd0);
    $display("op abort_len8: busy=%0b done=%0b equal=%0b", busy_o, done_o, equal_o);
    last_eq = 1'b0;

    run_op("pre_reset",  10'h010, 10'h020, 8'd4, 1'b1, 0, 1'b0);
    @(posedge clk_i); #1;
    a_base_i = 10'h010; b_base_i = 10'h020; len_i = 8'd8; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst rd_en", 32'(rd_en_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    check("midrst equal", 32'(equal_o), 32'd0);
    check("midrst a addr", 32'(rd_a_addr_o), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk_i); #1;
      if (done_o || rd_en_o || busy_o) seen = 1'b1;
    end
    check("midrst quiet", 32'(seen), 32'd0);
    $display("op reset_len8: busy=%0b done=%0b equal=%0b", busy_o, done_o, equal_o);
    last_eq = 1'b0;

    run_op("after_reset", 10'h010, 10'h020, 8'd4, 1'b1, 0, 1'b0);
    run_op("back2back",   10'h040, 10'h020, 8'd4, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
